mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface: accepts single load/store requests from the core datapath and drives MemRead/MemWrite, address and write data toward the data memory.
- The memory side has these fixed timings: read data updates on the clock falling edge while MemRead is high; writes commit on the clock rising edge while MemWrite is high.
- The block serialises requests and returns load data with a one-cycle response strobe.
- Sits between the control unit/register file and the data memory.

---
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory interface: serialises single load/store requests.
// Define MEM_ACCESS_VERIFY_EN to add a read-back verify of every store (reported on resp_err).
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int READ_WAIT  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] memDataIn
);

  localparam int CNT_WIDTH = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    WR_ISSUE = 3'd2,
    RESP     = 3'd3,
    VF_ISSUE = 3'd4,
    VF_CMP   = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 accept;
  logic                 wait_done;
`ifdef MEM_ACCESS_VERIFY_EN
  logic [DATA_WIDTH-1:0] vf_data;
`endif

  // req_ready is registered and held low in the first cycle after reset, so it gates acceptance
  assign accept    = req_valid && req_ready && (state == IDLE);
  assign wait_done = (wait_cnt == {CNT_WIDTH{1'b0}});

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = req_we ? WR_ISSUE : RD_ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      RD_ISSUE: begin
        if (wait_done) begin
          next_state = RESP;
        end else begin
          next_state = RD_ISSUE;
        end
      end
`ifdef MEM_ACCESS_VERIFY_EN
      WR_ISSUE: next_state = VF_ISSUE;
      VF_ISSUE: begin
        if (wait_done) begin
          next_state = VF_CMP;
        end else begin
          next_state = VF_ISSUE;
        end
      end
      VF_CMP:   next_state = RESP;
`else
      WR_ISSUE: next_state = RESP;
`endif
      RESP:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // State, wait counter, datapath latches and registered Moore outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= CNT_LOAD;
      req_ready    <= 1'b0;
      busy         <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= {DATA_WIDTH{1'b0}};
      resp_err     <= 1'b0;
      memAddress   <= {ADDR_WIDTH{1'b0}};
      memWriteData <= {DATA_WIDTH{1'b0}};
`ifdef MEM_ACCESS_VERIFY_EN
      vf_data      <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      state      <= next_state;
      req_ready  <= (next_state == IDLE);
      busy       <= (next_state != IDLE);
      MemRead    <= (next_state == RD_ISSUE) || (next_state == VF_ISSUE);
      MemWrite   <= (next_state == WR_ISSUE);
      resp_valid <= (next_state == RESP);
      if (accept) begin
        memAddress   <= req_addr;
        memWriteData <= req_wdata;
      end
      // Counter reloads in every non-read state, so each read phase starts fresh
      if ((state != RD_ISSUE) && (state != VF_ISSUE)) begin
        wait_cnt <= CNT_LOAD;
      end else if (!wait_done) begin
        wait_cnt <= wait_cnt - CNT_WIDTH'(1);
      end
      if ((state == RD_ISSUE) && wait_done) begin
        resp_rdata <= memDataIn;
      end
`ifdef MEM_ACCESS_VERIFY_EN
      if ((state == VF_ISSUE) && wait_done) begin
        vf_data <= memDataIn;
      end
      resp_err <= (state == VF_CMP) && (vf_data != memWriteData);
`else
      resp_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised self-checking bench: two controllers (READ_WAIT 1 and 3) against a memory model
// and a transaction-level reference model; honours MEM_ACCESS_VERIFY_EN (memory bit 0 stuck at 0).
module tb_mem_access_ctrl;

  localparam int RW0 = 1;
  localparam int RW1 = 3;
`ifdef MEM_ACCESS_VERIFY_EN
  localparam bit VF = 1'b1;
`else
  localparam bit VF = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       preload = 1'b1;
  logic       req_valid [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       req_ready [2];
  logic       resp_valid[2];
  logic [7:0] resp_rdata[2];
  logic       resp_err  [2];
  logic       busy      [2];
  logic [3:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic       mem_read  [2];
  logic       mem_write [2];
  logic [7:0] mem_din   [2];

  logic [7:0] mem       [2][16];
  logic [7:0] model_mem [2][16];
  logic [7:0] model_last[2];
  int         resp_cnt  [2];
  int         wr_cnt    [2];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_WAIT(RW0)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .busy(busy[0]), .memAddress(mem_addr[0]), .memWriteData(mem_wdata[0]),
    .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .memDataIn(mem_din[0]));

  mem_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_WAIT(RW1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .busy(busy[1]), .memAddress(mem_addr[1]), .memWriteData(mem_wdata[1]),
    .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .memDataIn(mem_din[1]));

  function automatic logic [7:0] init_val(input int a);
    if (a == 1) return 8'd15;
    else if (a == 2) return 8'd5;
    else return 8'(a * 17 + 3);
  endfunction

  // What the memory actually holds after a write of d
  function automatic logic [7:0] stored(input logic [7:0] d);
    return VF ? (d & 8'hFE) : d;
  endfunction

  function automatic int rw_of(input int i);
    return (i == 0) ? RW0 : RW1;
  endfunction

  // Memory write port (commits on rising edge) plus activity counters
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) begin
        for (int a = 0; a < 16; a++) mem[i][a] <= init_val(a);
        resp_cnt[i] <= 0;
        wr_cnt[i]   <= 0;
      end else begin
        if (mem_write[i]) mem[i][mem_addr[i]] <= stored(mem_wdata[i]);
        resp_cnt[i] <= resp_cnt[i] + (resp_valid[i] ? 1 : 0);
        wr_cnt[i]   <= wr_cnt[i] + (mem_write[i] ? 1 : 0);
      end
    end
  end

  // Memory read port (data updates on falling edge while MemRead is high)
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) mem_din[i] <= 8'h00;
      else if (mem_read[i]) mem_din[i] <= mem[i][mem_addr[i]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (!req_ready[i] && n < 40) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic check_outs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check(tag, {8'h0, req_ready[i], resp_valid[i], resp_err[i], busy[i], mem_read[i],
                  mem_write[i], resp_rdata[i], mem_wdata[i], mem_addr[i]}, 32'd0);
    end
  endtask

  // One full transaction on controller i, checked against the reference model
  task automatic do_txn(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    int lat, rd, wr, exp_lat, exp_rd;
    logic bad, exp_err;
    logic [7:0] exp_rdata;
    if (we) begin
      model_mem[i][a] = stored(d);
      exp_err   = VF && (stored(d) != d);
      exp_lat   = VF ? rw_of(i) + 3 : 2;
      exp_rd    = VF ? rw_of(i) : 0;
      exp_rdata = model_last[i];
    end else begin
      exp_rdata     = model_mem[i][a];
      model_last[i] = exp_rdata;
      exp_err       = 1'b0;
      exp_lat       = rw_of(i) + 1;
      exp_rd        = rw_of(i);
    end
    wait_ready(i);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    tick();
    req_valid[i] = 1'b0; req_addr[i] = ~a; req_wdata[i] = ~d;
    lat = 1; rd = 0; wr = 0; bad = 1'b0;
    while (!resp_valid[i] && lat < 30) begin
      if (mem_read[i]) rd++;
      if (mem_write[i]) wr++;
      if ((mem_read[i] || mem_write[i]) && mem_addr[i] != a) bad = 1'b1;
      if (mem_write[i] && mem_wdata[i] != d) bad = 1'b1;
      tick();
      lat++;
    end
    check(we ? "st_latency" : "ld_latency", 32'(lat), 32'(exp_lat));
    check("memread_cycles", 32'(rd), 32'(exp_rd));
    check("memwrite_cycles", 32'(wr), we ? 32'd1 : 32'd0);
    check("mem_addr_data", 32'(bad), 32'd0);
    check("resp_rdata", 32'(resp_rdata[i]), 32'(exp_rdata));
    check("resp_err", 32'(resp_err[i]), 32'(exp_err));
    tick();
    check("resp_pulse_end", {30'd0, resp_valid[i], req_ready[i]}, 32'd1);
  endtask

  initial begin
    int r0, w0, n;
    logic [7:0] d;
    logic [3:0] a;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 4'd0; req_wdata[i] = 8'd0;
      model_last[i] = 8'd0;
      for (int k = 0; k < 16; k++) model_mem[i][k] = init_val(k);
    end

    // Two reset cycles: every output low
    tick();
    check_outs_zero("reset_c1");
    tick();
    check_outs_zero("reset_c2");
    preload = 1'b0;
    reset = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 4'd1;
    tick();
    check("ignored_at_rst_exit", {30'd0, busy[0], mem_read[0]}, 32'd0);
    check("ready_after_rst", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b0;

    // Directed: load, store, load back, slow read, verify stores
    do_txn(0, 1'b0, 4'd1, 8'h00);
    do_txn(0, 1'b1, 4'd3, 8'hA5);
    do_txn(0, 1'b0, 4'd3, 8'h00);
    do_txn(1, 1'b0, 4'd2, 8'h00);
    do_txn(0, 1'b1, 4'd4, 8'h01);
    do_txn(0, 1'b1, 4'd5, 8'h02);
    do_txn(0, 1'b0, 4'd15, 8'h00);

    // req_valid held high: alternating store/load, accepted only from IDLE
    r0 = resp_cnt[0]; w0 = wr_cnt[0];
    req_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 4'(8 + k / 2);
      d = 8'($urandom_range(0, 255));
      req_we[0] = (k % 2 == 0); req_addr[0] = a; req_wdata[0] = d;
      if (k % 2 == 0) model_mem[0][a] = stored(d);
      else model_last[0] = model_mem[0][a];
      n = 0;
      while (!req_ready[0] && n < 40) begin
        check("b2b_ready_vs_busy", 32'(req_ready[0]), 32'(!busy[0]));
        tick();
        n++;
      end
      check("b2b_accept_wait", 32'(n < 40), 32'd1);
      tick();
      check("b2b_busy_after_accept", {30'd0, busy[0], req_ready[0]}, 32'd2);
    end
    req_valid[0] = 1'b0;
    wait_ready(0);
    check("b2b_resp_count", 32'(resp_cnt[0] - r0), 32'd8);
    check("b2b_write_count", 32'(wr_cnt[0] - w0), 32'd4);
    check("b2b_last_rdata", 32'(resp_rdata[0]), 32'(model_last[0]));

    // Reset in the middle of a 3-cycle read: no capture, rdata cleared
    wait_ready(1);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 4'd6;
    tick();
    req_valid[1] = 1'b0;
    tick();
    check("rd_mid_memread", 32'(mem_read[1]), 32'd1);
    r0 = resp_cnt[1];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last[0] = 8'd0; model_last[1] = 8'd0;
    check("rd_rst_rdata", 32'(resp_rdata[1]), 32'd0);
    check("rd_rst_memread", 32'(mem_read[1]), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    check("rd_rst_no_resp", 32'(resp_cnt[1] - r0), 32'd0);

    // Reset during WR_ISSUE: write still commits, response suppressed
    wait_ready(0);
    d = 8'h3C;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 4'd7; req_wdata[0] = d;
    tick();
    req_valid[0] = 1'b0;
    check("wr_mid_memwrite", 32'(mem_write[0]), 32'd1);
    r0 = resp_cnt[0];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_mem[0][7] = stored(d);
    check("wr_rst_outs", {30'd0, mem_write[0], resp_valid[0]}, 32'd0);
    for (int k = 0; k < 3; k++) tick();
    check("wr_rst_no_resp", 32'(resp_cnt[0] - r0), 32'd0);
    do_txn(0, 1'b0, 4'd7, 8'h00);

    // Randomised mix on both controllers
    for (int t = 0; t < 40; t++) begin
      do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
